// File: rtl/fetch_stage.sv
// Fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
// Holds the fetch PC, selects the next PC (pc+4 / branch / j,jal / jr),
// latches the fetched word into decode, and stops fetching on an exit syscall.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        pc_src_d,
    input  logic [31:0] pc_branch_d,
    input  logic [1:0]  sig_jump_d,
    input  logic [25:0] jump_index_d,
    input  logic [31:0] jr_addr_d,
    input  logic        halt_req_d,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        halted,
    output logic [31:0] fetch_count
);

    logic        is_j;
    logic        is_jr;
    logic        halt_fire;
    logic        redirect;
    logic [31:0] pc_plus4_f;
    logic [31:0] next_pc;

    assign imem_addr  = pc_f;
    assign pc_plus4_f = pc_f + 32'd4;
    assign is_j       = (sig_jump_d == 2'b01);
    assign is_jr      = (sig_jump_d == 2'b10);

    // The halting instruction's own redirect is dropped: fetch stops instead.
    assign halt_fire  = halt_req_d & valid_d & ~stall_d;
    assign redirect   = valid_d & ~halt_fire & (pc_src_d | is_j | is_jr);

    // Next-PC select, priority jr > j/jal > branch > sequential.
    always_comb begin
        next_pc = pc_plus4_f;
        if (redirect) begin
            if (is_jr)
                next_pc = jr_addr_d & 32'hFFFF_FFFC;
            else if (is_j)
                next_pc = (pc_plus4_d & 32'hF000_0000) | {4'b0000, jump_index_d, 2'b00};
            else
                next_pc = pc_branch_d & 32'hFFFF_FFFC;
        end
    end

    // Fetch PC register: frozen while halted or stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_f <= RESET_PC;
        else if (!halted && !stall_f)
            pc_f <= next_pc;
    end

    // IF/ID register: a stall holds (even over a redirect), a redirect or halt inserts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d     <= 32'd0;
            pc_plus4_d  <= 32'd0;
            valid_d     <= 1'b0;
            fetch_count <= 32'd0;
        end else if (stall_d) begin
            instr_d     <= instr_d;
            pc_plus4_d  <= pc_plus4_d;
            valid_d     <= valid_d;
        end else if (halted || redirect) begin
            instr_d     <= 32'd0;
            pc_plus4_d  <= 32'd0;
            valid_d     <= 1'b0;
        end else begin
            instr_d     <= imem_rdata;
            pc_plus4_d  <= pc_plus4_f;
            valid_d     <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

    // Sticky halt flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            halted <= 1'b0;
        else if (halt_fire)
            halted <= 1'b1;
    end

endmodule
